xintf_master: RTL
=================

XINTF_MASTER -- requirements
Module: xintf_master

Interface
REQ-001 SHALL have parameter LEAD_CYC, default 2, lead-phase length in clk50M cycles (legal range 1..31).
REQ-002 SHALL have parameter ACTIVE_CYC, default 5, active-phase length in cycles (1..31).
REQ-003 SHALL have parameter TRAIL_CYC, default 7, trail-phase length in cycles (1..31); the defaults total 14 cycles, i.e. 280 ns at 50 MHz.
REQ-004 SHALL have port clk50M, input, 1 bit, the single system clock; one clock only.
REQ-005 SHALL have port rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid, input, 1 bit, transaction request.
REQ-007 SHALL have port cmd_ready, output, 1 bit, high when the block accepts a command.
REQ-008 SHALL have port cmd_wr, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port cmd_addr, input, 19 bits, bus address.
REQ-010 SHALL have port cmd_wdata, input, 16 bits, write data.
REQ-011 SHALL have port rd_data, output, 16 bits, captured read data.
REQ-012 SHALL have port rd_valid, output, 1 bit, one-cycle pulse when rd_data is updated.
REQ-013 SHALL have port done, output, 1 bit, one-cycle pulse at the end of every transaction.
REQ-014 SHALL have port xcs_n, output, 1 bit, chip select, active-low.
REQ-015 SHALL have port xrd, output, 1 bit, read strobe, active-low.
REQ-016 SHALL have port xwe, output, 1 bit, write strobe, active-low.
REQ-017 SHALL have port xaddr, output, 19 bits, bus address.
REQ-018 SHALL have port xdata, inout, 16 bits, bidirectional data bus.

Function
REQ-019 FSM states SHALL be IDLE, LEAD, ACTIVE, TRAIL, GAP, with one shared 5-bit phase counter.
REQ-020 cmd_ready SHALL equal (state==IDLE); a command is accepted on the cycle where cmd_valid & cmd_ready.
REQ-021 On acceptance, the block SHALL register cmd_wr/cmd_addr/cmd_wdata and move to LEAD; command inputs are ignored outside IDLE.
REQ-022 In LEAD, ACTIVE and TRAIL, xcs_n SHALL be 0 and xaddr SHALL hold the registered address.
REQ-023 xrd (read) or xwe (write) SHALL be 0 in ACTIVE only, otherwise 1.
REQ-024 For a write, xdata SHALL be driven with the registered data from LEAD through TRAIL; in every other state and for reads, xdata SHALL be 16'hzzzz.
REQ-025 Each phase SHALL last exactly its parameter's cycle count: the counter runs 0..N-1, then clears on the phase change.
REQ-026 A read SHALL capture xdata into rd_data on the last ACTIVE cycle and pulse rd_valid in the following cycle (first TRAIL cycle).
REQ-027 After TRAIL the FSM SHALL enter GAP for one cycle (xcs_n=1, done=1), then return to IDLE.
REQ-028 Back-to-back commands SHALL therefore be separated by at least 2 cycles with xcs_n high (GAP, IDLE).
REQ-029 rd_data SHALL hold its value until the next read capture; writes leave it unchanged.
REQ-030 All bus outputs SHALL be registered, with no combinational path from cmd_* to x* pins.

Reset
REQ-031 While rst_n=0, outputs SHALL be: xcs_n=1, xrd=1, xwe=1, xaddr=0, xdata=Z, cmd_ready=0, rd_data=0, rd_valid=0, done=0, state=IDLE, counter=0.
REQ-032 Reset asserted mid-transaction SHALL abort it immediately, with no done or rd_valid pulse.
REQ-033 cmd_ready SHALL rise on the first clock after rst_n deasserts.

Configuration
REQ-034 Macro XINTF_MASTER_READY_EN defined: the block SHALL add port xready (input, 1 bit, active-high); when it is sampled 0 on the last ACTIVE cycle, ACTIVE SHALL extend cycle by cycle until xready=1, and read capture SHALL occur on the cycle where xready=1.
REQ-035 Macro XINTF_MASTER_READY_EN undefined: port xready SHALL be absent and timing SHALL be fixed per REQ-025.

Structure
REQ-036 The shared package xintf_pkg SHALL hold the FSM state enum, XINTF_AW=19, XINTF_DW=16, and the default LEAD/ACTIVE/TRAIL constants, also reused by the xintf slave.
REQ-037 The sub-module xintf_phase_cnt (load/count/terminal-count flag) SHALL be used for the phase counter; all other logic stays in xintf_master.

Verification
REQ-038 Write addr 19'h00100, data 16'hA5C3 at defaults -> xcs_n low for 14 cycles, xwe low for exactly cycles 3..7, xdata=A5C3 throughout, done one cycle after xcs_n rises.
REQ-039 Read with the bench driving xdata=16'h1234 during ACTIVE -> rd_data=1234, rd_valid single pulse, xdata never driven by the DUT.
REQ-040 cmd_valid held high for 3 commands -> each xcs_n assertion is separated by >=2 high cycles and cmd_ready is low during every transaction.
REQ-041 rst_n pulsed low in ACTIVE of a write -> all strobes go high and xdata goes Z asynchronously, with no done pulse.
REQ-042 With XINTF_MASTER_READY_EN and xready held 0 for 4 cycles -> ACTIVE lasts 9 cycles and data is captured on the xready=1 cycle.
REQ-043 Parameters LEAD=1, ACTIVE=1, TRAIL=1 -> the transaction spans 3 xcs_n-low cycles with the strobe low for 1 cycle.

Source files
------------

// File: rtl/xintf_pkg.sv
// Shared definitions for the XINTF master and slave: bus widths, default
// phase lengths and the transaction FSM state encoding.
package xintf_pkg;

  localparam int XINTF_AW = 19;
  localparam int XINTF_DW = 16;
  localparam int XINTF_CW = 5;

  // Default phase lengths in clk50M cycles (2 + 5 + 7 = 280 ns at 50 MHz)
  localparam int XINTF_LEAD_CYC   = 2;
  localparam int XINTF_ACTIVE_CYC = 5;
  localparam int XINTF_TRAIL_CYC  = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_TRAIL  = 3'd3,
    ST_GAP    = 3'd4
  } xintf_state_e;

  // Chip select is asserted only while a bus phase is in progress
  function automatic logic is_bus_phase(input xintf_state_e s);
    return (s == ST_LEAD) || (s == ST_ACTIVE) || (s == ST_TRAIL);
  endfunction

endpackage

// File: rtl/xintf_phase_cnt.sv
// Shared phase counter: counts 0..N-1 within a phase; the owner supplies the
// terminal value N-1 for the current phase and reloads to zero on phase change.
module xintf_phase_cnt
  import xintf_pkg::*;
(
  input  logic                clk50M,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic                i_en,
  input  logic [XINTF_CW-1:0] i_tc_val,
  output logic                o_tc
);

  logic [XINTF_CW-1:0] r_cnt;

  // Clear on load, otherwise advance when enabled (hold when neither)
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == i_tc_val);

endmodule

// File: rtl/xintf_master.sv
// XINTF bus master: turns one command into a LEAD/ACTIVE/TRAIL strobe
// sequence followed by a one-cycle GAP. All bus pins come straight from flops.
// Optional macro XINTF_MASTER_READY_EN adds the xready input, which stretches
// ACTIVE until the slave signals ready.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// LEAD   | xcs_n low, address (and write data) set up, strobes inactive
// ACTIVE | xrd or xwe low; read data captured on the final cycle
// TRAIL  | strobe released, xcs_n/address/write data held
// GAP    | xcs_n high for one cycle, done pulse
module xintf_master
  import xintf_pkg::*;
#(
  parameter int LEAD_CYC   = XINTF_LEAD_CYC,
  parameter int ACTIVE_CYC = XINTF_ACTIVE_CYC,
  parameter int TRAIL_CYC  = XINTF_TRAIL_CYC
) (
  input  logic                clk50M,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [XINTF_AW-1:0] cmd_addr,
  input  logic [XINTF_DW-1:0] cmd_wdata,
  output logic [XINTF_DW-1:0] rd_data,
  output logic                rd_valid,
  output logic                done,
`ifdef XINTF_MASTER_READY_EN
  input  logic                xready,
`endif
  output logic                xcs_n,
  output logic                xrd,
  output logic                xwe,
  output logic [XINTF_AW-1:0] xaddr,
  inout  wire  [XINTF_DW-1:0] xdata
);

  localparam logic [XINTF_CW-1:0] LEAD_TC   = XINTF_CW'(LEAD_CYC - 1);
  localparam logic [XINTF_CW-1:0] ACTIVE_TC = XINTF_CW'(ACTIVE_CYC - 1);
  localparam logic [XINTF_CW-1:0] TRAIL_TC  = XINTF_CW'(TRAIL_CYC - 1);

  xintf_state_e        r_state;
  xintf_state_e        w_state_nxt;
  logic                r_wr;
  logic [XINTF_AW-1:0] r_addr;
  logic [XINTF_DW-1:0] r_wdata;
  logic                r_ready;
  logic                r_xcs_n;
  logic                r_xrd;
  logic                r_xwe;
  logic                r_oe;
  logic                r_done;
  logic                r_rd_valid;
  logic [XINTF_DW-1:0] r_rd_data;

  logic                w_accept;
  logic                w_ready_ok;
  logic                w_capture;
  logic                w_wr_nxt;
  logic                w_cnt_load;
  logic                w_cnt_en;
  logic                w_tc;
  logic [XINTF_CW-1:0] w_tc_val;

`ifdef XINTF_MASTER_READY_EN
  assign w_ready_ok = xready;
`else
  assign w_ready_ok = 1'b1;
`endif

  // r_ready is only ever high in IDLE, so it alone qualifies acceptance
  assign w_accept  = cmd_valid & r_ready;
  assign w_wr_nxt  = w_accept ? cmd_wr : r_wr;
  assign w_capture = (r_state == ST_ACTIVE) & w_tc & w_ready_ok & ~r_wr;

  xintf_phase_cnt u_phase_cnt (
    .clk50M   (clk50M),
    .rst_n    (rst_n),
    .i_load   (w_cnt_load),
    .i_en     (w_cnt_en),
    .i_tc_val (w_tc_val),
    .o_tc     (w_tc)
  );

  // Terminal count for the phase currently running
  always_comb begin
    w_tc_val = '0;
    case (r_state)
      ST_LEAD:   w_tc_val = LEAD_TC;
      ST_ACTIVE: w_tc_val = ACTIVE_TC;
      ST_TRAIL:  w_tc_val = TRAIL_TC;
      default:   w_tc_val = '0;
    endcase
  end

  // Next state and phase counter control
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b1;
    w_cnt_en    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_LEAD;
      end
      ST_LEAD: begin
        if (w_tc) begin
          w_state_nxt = ST_ACTIVE;
        end else begin
          w_cnt_load = 1'b0;
          w_cnt_en   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_tc && w_ready_ok) begin
          w_state_nxt = ST_TRAIL;
        end else begin
          // Counter parks on its terminal value while the slave stalls
          w_cnt_load = 1'b0;
          w_cnt_en   = ~w_tc;
        end
      end
      ST_TRAIL: begin
        if (w_tc) begin
          w_state_nxt = ST_GAP;
        end else begin
          w_cnt_load = 1'b0;
          w_cnt_en   = 1'b1;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command capture; inputs are ignored outside IDLE
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_wr    <= cmd_wr;
      r_addr  <= cmd_addr;
      r_wdata <= cmd_wdata;
    end
  end

  // Bus and handshake outputs, decoded from the next state so they line up with it
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_ready    <= 1'b0;
      r_xcs_n    <= 1'b1;
      r_xrd      <= 1'b1;
      r_xwe      <= 1'b1;
      r_oe       <= 1'b0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_ready    <= (w_state_nxt == ST_IDLE);
      r_xcs_n    <= ~is_bus_phase(w_state_nxt);
      r_xrd      <= ~((w_state_nxt == ST_ACTIVE) & ~w_wr_nxt);
      r_xwe      <= ~((w_state_nxt == ST_ACTIVE) & w_wr_nxt);
      r_oe       <= is_bus_phase(w_state_nxt) & w_wr_nxt;
      r_done     <= (w_state_nxt == ST_GAP);
      r_rd_valid <= w_capture;
    end
  end

  // Read data holds until the next read capture
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (w_capture) begin
      r_rd_data <= xdata;
    end
  end

  assign cmd_ready = r_ready;
  assign xcs_n     = r_xcs_n;
  assign xrd       = r_xrd;
  assign xwe       = r_xwe;
  assign xaddr     = r_addr;
  assign xdata     = r_oe ? r_wdata : {XINTF_DW{1'bz}};
  assign done      = r_done;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;

endmodule
